// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU operation sequencer: the sequencer state
// enum, the multiply command codes that select the longer ALU latency, the
// bit positions of the packed response flags and a helper that classifies
// a command as a multiply.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  // Arithmetic-mode commands that take the multiply latency
  localparam logic [3:0] CMD_MUL_A = 4'd9;
  localparam logic [3:0] CMD_MUL_B = 4'd10;

  // Packed response flags: {err, e, l, g, cout, oflow}
  localparam int FLAG_OFLOW = 0;
  localparam int FLAG_COUT  = 1;
  localparam int FLAG_G     = 2;
  localparam int FLAG_L     = 3;
  localparam int FLAG_E     = 4;
  localparam int FLAG_ERR   = 5;
  localparam int NUM_FLAGS  = 6;

  // Multiplies only exist in arithmetic mode (mode=1)
  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && ((cmd == CMD_MUL_A) || (cmd == CMD_MUL_B));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter, purely combinational. The pointer of the
// last winner is kept by the parent so that it only advances on an
// accepted request.
//   req[1:0]     request lines, bit i = requester i
//   last_grant   index of the requester that won most recently
//   grant_valid  at least one request is present
//   grant_idx    index of the winning requester
module rr_arb2
  import alu_seq_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  // A lone requester always wins; on a tie the one that did not win last
  // time gets the grant.
  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Shares one ALU between two requesters. A request is accepted in IDLE
// through a round-robin grant, its operands/command are registered onto the
// ALU ports with alu_ce held high for the command's latency, then the ALU
// result and flags are captured and offered on a back-pressurable response
// channel tagged with the requester index.
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/req_ready [1:0]      per-requester handshake
//   req_opa/req_opb [2*WIDTH-1:0]  operands, requester i in [i*WIDTH +: WIDTH]
//   req_cmd [7:0], req_inp_valid [3:0], req_mode/req_cin [1:0]
//                                  per-requester command fields
//   alu_*                          1:1 connection to the ALU
//   rsp_valid/rsp_ready            response handshake
//   rsp_id, rsp_res, rsp_flags     requester index, result, {err,e,l,g,cout,oflow}
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LAT_STD = 1,
  parameter int LAT_MUL = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*WIDTH-1:0]     req_opa,
  input  logic [2*WIDTH-1:0]     req_opb,
  input  logic [7:0]             req_cmd,
  input  logic [3:0]             req_inp_valid,
  input  logic [1:0]             req_mode,
  input  logic [1:0]             req_cin,
  output logic [WIDTH-1:0]       alu_opa,
  output logic [WIDTH-1:0]       alu_opb,
  output logic [3:0]             alu_cmd,
  output logic [1:0]             alu_inp_valid,
  output logic                   alu_mode,
  output logic                   alu_cin,
  output logic                   alu_ce,
  input  logic [WIDTH+1:0]       alu_res,
  input  logic                   alu_oflow,
  input  logic                   alu_cout,
  input  logic                   alu_g,
  input  logic                   alu_l,
  input  logic                   alu_e,
  input  logic                   alu_err,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [WIDTH+1:0]       rsp_res,
  output logic [NUM_FLAGS-1:0]   rsp_flags
);

  localparam int LAT_MAX = (LAT_MUL > LAT_STD) ? LAT_MUL : LAT_STD;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  seq_state_t           state;
  seq_state_t           state_next;
  logic                 last_grant;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 grant_valid;
  logic                 grant_idx;
  logic                 accept;
  logic                 capture;
  logic                 rsp_done;

  logic [WIDTH-1:0]     sel_opa;
  logic [WIDTH-1:0]     sel_opb;
  logic [3:0]           sel_cmd;
  logic [1:0]           sel_inp_valid;
  logic                 sel_mode;
  logic                 sel_cin;
  logic [CNT_W-1:0]     sel_lat;
  logic [NUM_FLAGS-1:0] flags_in;

  rr_arb2 u_arb (
    .req         (req_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Fields of the granted requester and the latency its command needs
  assign sel_opa       = grant_idx ? req_opa[2*WIDTH-1:WIDTH] : req_opa[WIDTH-1:0];
  assign sel_opb       = grant_idx ? req_opb[2*WIDTH-1:WIDTH] : req_opb[WIDTH-1:0];
  assign sel_cmd       = grant_idx ? req_cmd[7:4] : req_cmd[3:0];
  assign sel_inp_valid = grant_idx ? req_inp_valid[3:2] : req_inp_valid[1:0];
  assign sel_mode      = grant_idx ? req_mode[1] : req_mode[0];
  assign sel_cin       = grant_idx ? req_cin[1] : req_cin[0];
  assign sel_lat       = is_mul(sel_mode, sel_cmd) ? CNT_W'(LAT_MUL) : CNT_W'(LAT_STD);

  // Pack the ALU status bits into the response flag layout
  always_comb begin
    flags_in            = '0;
    flags_in[FLAG_OFLOW] = alu_oflow;
    flags_in[FLAG_COUT]  = alu_cout;
    flags_in[FLAG_G]     = alu_g;
    flags_in[FLAG_L]     = alu_l;
    flags_in[FLAG_E]     = alu_e;
    flags_in[FLAG_ERR]   = alu_err;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle strobes. req_ready only ever rises in IDLE so
  // a request waiting behind a busy ALU is stalled, never dropped. The
  // counter check uses <= 1 so a stray zero can never wedge the FSM.
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    accept     = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_next           = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt <= CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load the ALU ports on accept, count down the latency,
  // capture the result, and hold the response until it is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_opa       <= '0;
      alu_opb       <= '0;
      alu_cmd       <= '0;
      alu_inp_valid <= '0;
      alu_mode      <= 1'b0;
      alu_cin       <= 1'b0;
      alu_ce        <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_res       <= '0;
      rsp_flags     <= '0;
      last_grant    <= 1'b1;
      wait_cnt      <= '0;
    end else begin
      if (accept) begin
        alu_opa       <= sel_opa;
        alu_opb       <= sel_opb;
        alu_cmd       <= sel_cmd;
        alu_inp_valid <= sel_inp_valid;
        alu_mode      <= sel_mode;
        alu_cin       <= sel_cin;
        alu_ce        <= 1'b1;
        last_grant    <= grant_idx;
        rsp_id        <= grant_idx;
        wait_cnt      <= sel_lat;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (capture) begin
        rsp_res       <= alu_res;
        rsp_flags     <= flags_in;
        rsp_valid     <= 1'b1;
        alu_ce        <= 1'b0;
        alu_inp_valid <= 2'b00;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Bench for alu_op_sequencer. A small behavioural ALU answers the DUT's ALU
// ports, a transaction-level model predicts handshakes and responses, one
// process compares the DUT against the model on every falling edge, and
// directed tests pin literal values for latency, arbitration order,
// back-pressure, reset and error pass-through.
module tb_alu_op_sequencer;

  localparam int WIDTH   = 8;
  localparam int LAT_STD = 1;
  localparam int LAT_MUL = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_opa;
  logic [2*WIDTH-1:0] req_opb;
  logic [7:0]         req_cmd;
  logic [3:0]         req_inp_valid;
  logic [1:0]         req_mode;
  logic [1:0]         req_cin;
  logic [WIDTH-1:0]   alu_opa;
  logic [WIDTH-1:0]   alu_opb;
  logic [3:0]         alu_cmd;
  logic [1:0]         alu_inp_valid;
  logic               alu_mode;
  logic               alu_cin;
  logic               alu_ce;
  logic [WIDTH+1:0]   alu_res;
  logic               alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH+1:0]   rsp_res;
  logic [5:0]         rsp_flags;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.WIDTH(WIDTH), .LAT_STD(LAT_STD), .LAT_MUL(LAT_MUL)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_opa       (req_opa),
    .req_opb       (req_opb),
    .req_cmd       (req_cmd),
    .req_inp_valid (req_inp_valid),
    .req_mode      (req_mode),
    .req_cin       (req_cin),
    .alu_opa       (alu_opa),
    .alu_opb       (alu_opb),
    .alu_cmd       (alu_cmd),
    .alu_inp_valid (alu_inp_valid),
    .alu_mode      (alu_mode),
    .alu_cin       (alu_cin),
    .alu_ce        (alu_ce),
    .alu_res       (alu_res),
    .alu_oflow     (alu_oflow),
    .alu_cout      (alu_cout),
    .alu_g         (alu_g),
    .alu_l         (alu_l),
    .alu_e         (alu_e),
    .alu_err       (alu_err),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_res       (rsp_res),
    .rsp_flags     (rsp_flags)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {res[9:0], err, e, l, g, cout, oflow}
  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] cmd, input logic mode,
                                            input logic cin, input logic [1:0] iv);
    logic [9:0]  res;
    logic [5:0]  fl;
    logic [8:0]  sum;
    logic [15:0] prod;
    res  = '0;
    fl   = '0;
    sum  = '0;
    prod = '0;
    if (mode && (iv != 2'b11)) begin
      fl[5] = 1'b1;
    end else if (mode) begin
      case (cmd)
        4'd0: begin
          sum   = {1'b0, a} + {1'b0, b} + {8'd0, cin};
          res   = {1'b0, sum};
          fl[1] = sum[8];
          fl[0] = (a[7] == b[7]) && (sum[7] != a[7]);
        end
        4'd8: begin
          fl[2] = a > b;
          fl[3] = a < b;
          fl[4] = a == b;
        end
        4'd9: begin
          prod = 16'(a) * 16'(b);
          res  = prod[9:0];
        end
        4'd10: begin
          prod = (16'(a) * 16'(b)) << 1;
          res  = prod[9:0];
        end
        default: res = {2'b00, a - b};
      endcase
    end else begin
      if (cmd == 4'd0) res = {2'b00, a & b};
      else             res = {2'b00, a | b};
    end
    return {res, fl};
  endfunction

  // The ALU answers only while enabled; otherwise it shows an all-ones pattern
  always_comb begin
    {alu_res, alu_err, alu_e, alu_l, alu_g, alu_cout, alu_oflow} = 16'hFFFF;
    if (alu_ce) begin
      {alu_res, alu_err, alu_e, alu_l, alu_g, alu_cout, alu_oflow} =
        alu_model(alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid);
    end
  end

  // Round-robin rule: lone requester wins; a tie goes to the non-last winner
  function automatic logic grant_of(input logic [1:0] v, input logic last);
    if (v == 2'b11) return ~last;
    return v[1];
  endfunction

  // Transaction model: an op occupies the ALU for its latency, then a
  // response is pending until taken.
  logic        m_init = 1'b0;
  logic        m_busy, m_pend, m_last;
  int          m_left;
  logic [7:0]  e_opa, e_opb;
  logic [3:0]  e_cmd;
  logic        e_mode, e_cin, e_id;
  logic [1:0]  e_iv;
  logic [9:0]  e_res;
  logic [5:0]  e_flags;
  logic        g_idx;
  logic [7:0]  g_opa, g_opb;
  logic [3:0]  g_cmd;
  logic        g_mode, g_cin;
  logic [1:0]  g_iv;

  assign g_idx  = grant_of(req_valid, m_last);
  assign g_opa  = g_idx ? req_opa[15:8] : req_opa[7:0];
  assign g_opb  = g_idx ? req_opb[15:8] : req_opb[7:0];
  assign g_cmd  = g_idx ? req_cmd[7:4] : req_cmd[3:0];
  assign g_mode = g_idx ? req_mode[1] : req_mode[0];
  assign g_cin  = g_idx ? req_cin[1] : req_cin[0];
  assign g_iv   = g_idx ? req_inp_valid[3:2] : req_inp_valid[1:0];

  always @(posedge clk) begin
    if (reset) begin
      m_init <= 1'b1;
      m_busy <= 1'b0;
      m_pend <= 1'b0;
      m_last <= 1'b1;
      m_left <= 0;
    end else if (m_init) begin
      if (m_pend) begin
        if (rsp_ready) m_pend <= 1'b0;
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_pend <= 1'b1;
        end
      end else if (req_valid != 2'b00) begin
        m_busy  <= 1'b1;
        m_last  <= g_idx;
        e_id    <= g_idx;
        e_opa   <= g_opa;
        e_opb   <= g_opb;
        e_cmd   <= g_cmd;
        e_mode  <= g_mode;
        e_cin   <= g_cin;
        e_iv    <= g_iv;
        m_left  <= (g_mode && (g_cmd == 4'd9 || g_cmd == 4'd10)) ? LAT_MUL : LAT_STD;
        {e_res, e_flags} <= alu_model(g_opa, g_opb, g_cmd, g_mode, g_cin, g_iv);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_init) begin
      checkOutput("req_ready", 32'(req_ready),
                  (m_busy || m_pend) ? 32'd0 : 32'(req_valid == 2'b00 ? 2'b00 :
                                                 (grant_of(req_valid, m_last) ? 2'b10 : 2'b01)));
      checkOutput("alu_ce", 32'(alu_ce), 32'(m_busy));
      checkOutput("alu_inp_valid", 32'(alu_inp_valid), m_busy ? 32'(e_iv) : 32'd0);
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_pend));
      if (m_busy) begin
        checkOutput("alu_opa", 32'(alu_opa), 32'(e_opa));
        checkOutput("alu_opb", 32'(alu_opb), 32'(e_opb));
        checkOutput("alu_cmd", 32'(alu_cmd), 32'(e_cmd));
        checkOutput("alu_mode", 32'(alu_mode), 32'(e_mode));
        checkOutput("alu_cin", 32'(alu_cin), 32'(e_cin));
      end
      if (m_pend) begin
        checkOutput("rsp_id", 32'(rsp_id), 32'(e_id));
        checkOutput("rsp_res", 32'(rsp_res), 32'(e_res));
        checkOutput("rsp_flags", 32'(rsp_flags), 32'(e_flags));
      end
    end
  end

  // Observation of timing and grant order straight from the DUT pins
  int         cyc = 0;
  int         acc_cyc = 0;
  int         rv_cyc = 0;
  int         ce_cnt = 0;
  int         acc_count = 0;
  logic       rv_prev = 1'b0;
  logic       id_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && ((req_valid & req_ready) != 2'b00)) begin
      acc_cyc   <= cyc + 1;
      acc_count <= acc_count + 1;
      ce_cnt    <= 0;
    end else if (alu_ce) begin
      ce_cnt <= ce_cnt + 1;
    end
    if (rsp_valid && !rv_prev) rv_cyc <= cyc;
    rv_prev <= rsp_valid;
    if (rsp_valid && rsp_ready && !reset) id_log.push_back(rsp_id);
  end

  task automatic setFields(input int idx, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] cmd, input logic mode, input logic cin,
                           input logic [1:0] iv);
    req_opa[idx*WIDTH +: WIDTH] = a;
    req_opb[idx*WIDTH +: WIDTH] = b;
    req_cmd[idx*4 +: 4]         = cmd;
    req_inp_valid[idx*2 +: 2]   = iv;
    req_mode[idx]               = mode;
    req_cin[idx]                = cin;
  endtask

  // Present one request and return one cycle after its accept edge;
  // wcycles = falling edges seen until req_ready came up.
  task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] cmd, input logic mode, input logic cin,
                               input logic [1:0] iv, output int wcycles);
    bit ok;
    @(posedge clk); #1;
    setFields(idx, a, b, cmd, mode, cin, iv);
    req_valid[idx] = 1'b1;
    ok = 0;
    wcycles = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      wcycles++;
      if (req_ready[idx]) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: requester %0d never got req_ready", idx);
    end
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic waitResponse();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
    end
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_timeout: rsp_valid never rose");
    end
  endtask

  task automatic finishResponse();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int wc;
    int base_acc;
    int base_log;
    int rv_seen;
    bit ok;

    reset = 1'b1;
    req_valid = '0;
    req_opa = '0;
    req_opb = '0;
    req_cmd = '0;
    req_inp_valid = '0;
    req_mode = '0;
    req_cin = '0;
    rsp_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_alu_ce", 32'(alu_ce), 32'd0);
    checkOutput("reset_alu_opa", 32'(alu_opa), 32'd0);
    checkOutput("reset_alu_cmd", 32'(alu_cmd), 32'd0);
    checkOutput("reset_alu_inp_valid", 32'(alu_inp_valid), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_rsp_res", 32'(rsp_res), 32'd0);
    checkOutput("reset_rsp_flags", 32'(rsp_flags), 32'd0);
    reset = 1'b0;

    // Single ADD on requester 0: 5 + 3
    applyStimulus(0, 8'h05, 8'h03, 4'd0, 1'b1, 1'b0, 2'b11, wc);
    waitResponse();
    checkOutput("add_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("add_rsp_res", 32'(rsp_res), 32'h008);
    checkOutput("add_rsp_flags", 32'(rsp_flags), 32'd0);
    checkOutput("add_latency", 32'(rv_cyc - acc_cyc), 32'd1);
    checkOutput("add_ce_cycles", 32'(ce_cnt), 32'd1);
    finishResponse();

    // Multiply on requester 1: 2 * 3 with the longer latency
    applyStimulus(1, 8'h02, 8'h03, 4'd9, 1'b1, 1'b0, 2'b11, wc);
    waitResponse();
    checkOutput("mul_rsp_id", 32'(rsp_id), 32'd1);
    checkOutput("mul_rsp_res", 32'(rsp_res), 32'h006);
    checkOutput("mul_latency", 32'(rv_cyc - acc_cyc), 32'd2);
    checkOutput("mul_ce_cycles", 32'(ce_cnt), 32'd2);
    finishResponse();

    // Round-robin with both requesters held valid for four ops
    setFields(0, 8'h01, 8'h01, 4'd0, 1'b1, 1'b0, 2'b11);
    setFields(1, 8'h03, 8'h04, 4'd9, 1'b1, 1'b0, 2'b11);
    base_acc = acc_count;
    base_log = id_log.size();
    @(posedge clk); #1;
    req_valid = 2'b11;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (acc_count >= base_acc + 4) ok = 1;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int i = 0; i < 50 && id_log.size() < base_log + 4; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("rr_count", 32'(id_log.size() - base_log), 32'd4);
    if (id_log.size() >= base_log + 4) begin
      checkOutput("rr_grant0", 32'(id_log[base_log]), 32'd0);
      checkOutput("rr_grant1", 32'(id_log[base_log + 1]), 32'd1);
      checkOutput("rr_grant2", 32'(id_log[base_log + 2]), 32'd0);
      checkOutput("rr_grant3", 32'(id_log[base_log + 3]), 32'd1);
    end

    // Requester 1 alone right after it won: still granted at once
    applyStimulus(1, 8'hF0, 8'h20, 4'd0, 1'b1, 1'b0, 2'b11, wc);
    checkOutput("alone_wait", 32'(wc), 32'd1);
    waitResponse();
    checkOutput("carry_rsp_res", 32'(rsp_res), 32'h110);
    checkOutput("carry_rsp_flags", 32'(rsp_flags), 32'b000010);
    finishResponse();

    // Back-pressure: response held while rsp_ready is low
    rsp_ready = 1'b0;
    applyStimulus(0, 8'h70, 8'h20, 4'd0, 1'b1, 1'b0, 2'b11, wc);
    setFields(1, 8'h09, 8'h03, 4'd8, 1'b1, 1'b0, 2'b11);
    req_valid[1] = 1'b1;
    waitResponse();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_res", 32'(rsp_res), 32'h090);
      checkOutput("bp_rsp_flags", 32'(rsp_flags), 32'b000001);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bp_release_ready", 32'(req_ready), 32'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    waitResponse();
    checkOutput("cmp_rsp_id", 32'(rsp_id), 32'd1);
    checkOutput("cmp_rsp_flags", 32'(rsp_flags), 32'b000100);
    finishResponse();

    // Reset one cycle into a multiply: nothing may come out of it
    applyStimulus(0, 8'h07, 8'h07, 4'd9, 1'b1, 1'b0, 2'b11, wc);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rst_alu_ce", 32'(alu_ce), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) rv_seen++;
    end
    checkOutput("rst_no_response", 32'(rv_seen), 32'd0);
    setFields(0, 8'h03, 8'h09, 4'd8, 1'b1, 1'b0, 2'b11);
    setFields(1, 8'h01, 8'h02, 4'd0, 1'b1, 1'b0, 2'b11);
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("rst_tie_grant", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    waitResponse();
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("less_rsp_flags", 32'(rsp_flags), 32'b001000);
    finishResponse();

    // ALU error is reported, not acted on
    applyStimulus(1, 8'h05, 8'h05, 4'd0, 1'b1, 1'b0, 2'b00, wc);
    waitResponse();
    checkOutput("err_rsp_flags", 32'(rsp_flags), 32'b100000);
    checkOutput("err_rsp_res", 32'(rsp_res), 32'h000);
    finishResponse();
    applyStimulus(0, 8'h05, 8'h05, 4'd8, 1'b1, 1'b0, 2'b11, wc);
    checkOutput("err_then_idle_wait", 32'(wc), 32'd1);
    waitResponse();
    checkOutput("eq_rsp_flags", 32'(rsp_flags), 32'b010000);
    finishResponse();

    // Logic mode AND
    applyStimulus(1, 8'hF0, 8'h3C, 4'd0, 1'b0, 1'b0, 2'b11, wc);
    waitResponse();
    checkOutput("and_rsp_res", 32'(rsp_res), 32'h030);
    checkOutput("and_rsp_flags", 32'(rsp_flags), 32'd0);
    finishResponse();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
